// File: rtl/ctrl_pipeline_pkg.sv
// Shared opcode encodings, control-field layout and the decoded-control bundle
// used by the MIPS pipelined control block and its decoder.
package ctrl_pipeline_pkg;

    localparam int OPC_W = 6;

    localparam logic [OPC_W-1:0] OP_RTYPE = 6'd0;
    localparam logic [OPC_W-1:0] OP_J     = 6'd2;
    localparam logic [OPC_W-1:0] OP_BEQ   = 6'd4;
    localparam logic [OPC_W-1:0] OP_BNE   = 6'd5;
    localparam logic [OPC_W-1:0] OP_ADDI  = 6'd8;
    localparam logic [OPC_W-1:0] OP_SLTI  = 6'd10;
    localparam logic [OPC_W-1:0] OP_ANDI  = 6'd12;
    localparam logic [OPC_W-1:0] OP_ORI   = 6'd13;
    localparam logic [OPC_W-1:0] OP_XORI  = 6'd14;
    localparam logic [OPC_W-1:0] OP_LUI   = 6'd15;
    localparam logic [OPC_W-1:0] OP_LB    = 6'd32;
    localparam logic [OPC_W-1:0] OP_LW    = 6'd35;
    localparam logic [OPC_W-1:0] OP_SB    = 6'd40;
    localparam logic [OPC_W-1:0] OP_SW    = 6'd43;

    localparam int EX_W  = 4;
    localparam int MEM_W = 4;
    localparam int WB_W  = 2;

    // MEM field bit positions: {Branch, BranchNE, MemRead, MemWrite}
    localparam int MEM_BRANCH   = 3;
    localparam int MEM_BRANCHNE = 2;
    localparam int MEM_MEMREAD  = 1;
    localparam int MEM_MEMWRITE = 0;

    typedef struct packed {
        logic [EX_W-1:0]  ex;
        logic [MEM_W-1:0] mem;
        logic [WB_W-1:0]  wb;
        logic             byteAcc;
    } ctrlFields_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decode into EX/MEM/WB control fields plus jump/illegal flags;
// zero latency, invalid slots decode to all-zero controls.
module ctrl_decoder
    import ctrl_pipeline_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            valid,
    input  logic [OP_W-1:0] opcode,
    output ctrlFields_t     fields,
    output logic            jump,
    output logic            illegal
);

    always_comb begin
        fields  = '0;
        jump    = 1'b0;
        illegal = 1'b0;
        if (valid) begin
            case (opcode)
                OP_W'(OP_RTYPE): begin
                    fields.ex = 4'b1100;
                    fields.wb = 2'b10;
                end
                OP_W'(OP_LW), OP_W'(OP_LB): begin
                    fields.ex      = 4'b0001;
                    fields.mem     = 4'b0010;
                    fields.wb      = 2'b11;
                    fields.byteAcc = (opcode == OP_W'(OP_LB));
                end
                OP_W'(OP_SW), OP_W'(OP_SB): begin
                    fields.ex      = 4'b0001;
                    fields.mem     = 4'b0001;
                    fields.byteAcc = (opcode == OP_W'(OP_SB));
                end
                OP_W'(OP_BEQ): begin
                    fields.ex  = 4'b0010;
                    fields.mem = 4'b1000;
                end
                OP_W'(OP_BNE): begin
                    fields.ex  = 4'b0010;
                    fields.mem = 4'b0100;
                end
                OP_W'(OP_ADDI), OP_W'(OP_SLTI), OP_W'(OP_ANDI),
                OP_W'(OP_ORI), OP_W'(OP_XORI), OP_W'(OP_LUI): begin
                    fields.ex = 4'b0111;
                    fields.wb = 2'b10;
                end
                OP_W'(OP_J): jump = 1'b1;
                default:     illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Pipelined MIPS control: ID/EX, EX/MEM, MEM/WB control registers (1/2/3 clk after decode),
// load-use bubble with PC/IF-ID hold; i_stall freezes everything, i_flush bubbles ID/EX.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic [OP_W-1:0]   i_opcode,
    input  logic [REG_W-1:0]  i_rs,
    input  logic [REG_W-1:0]  i_rt,
    input  logic              i_flush,
    input  logic              i_stall,
    output logic [EX_W-1:0]   o_ex_ctrl,
    output logic [MEM_W-1:0]  o_mem_ctrl,
    output logic [WB_W-1:0]   o_wb_ctrl,
    output logic              o_byte,
    output logic              o_jump,
    output logic              o_pc_write,
    output logic              o_ifid_write,
    output logic              o_illegal,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    ctrlFields_t      decFields;
    logic             decJump;
    logic             decIllegal;

    ctrlFields_t      idexQ;
    logic [REG_W-1:0] idexRt;
    logic             illegalQ;
    logic [MEM_W-1:0] exmemMem;
    logic [WB_W-1:0]  exmemWb;
    logic             exmemByte;
    logic [WB_W-1:0]  memwbWb;
    logic [CNT_W-1:0] stallCnt;

    logic             loadUse;
    logic             luStall;
    logic             bubble;

    ctrl_decoder #(
        .OP_W (OP_W)
    ) u_decoder (
        .valid   (i_valid),
        .opcode  (i_opcode),
        .fields  (decFields),
        .jump    (decJump),
        .illegal (decIllegal)
    );

    assign loadUse = idexQ.mem[MEM_MEMREAD] && (idexRt != '0)
                     && ((idexRt == i_rs) || (idexRt == i_rt)) && i_valid;
    // A flush outranks the hazard: the dependent instruction is being killed anyway.
    assign luStall = loadUse && !i_flush && !i_stall;
    assign bubble  = i_flush || loadUse;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idexQ     <= '0;
            idexRt    <= '0;
            illegalQ  <= 1'b0;
            exmemMem  <= '0;
            exmemWb   <= '0;
            exmemByte <= 1'b0;
            memwbWb   <= '0;
            stallCnt  <= '0;
        end else if (!i_stall) begin
            exmemMem  <= idexQ.mem;
            exmemWb   <= idexQ.wb;
            exmemByte <= idexQ.byteAcc;
            memwbWb   <= exmemWb;
            if (bubble) begin
                idexQ    <= '0;
                illegalQ <= 1'b0;
            end else begin
                idexQ    <= decFields;
                idexRt   <= i_rt;
                illegalQ <= decIllegal;
            end
            if (luStall && (stallCnt != '1)) begin
                stallCnt <= stallCnt + CNT_W'(1);
            end
        end
    end

    assign o_ex_ctrl    = idexQ.ex;
    assign o_mem_ctrl   = exmemMem;
    assign o_wb_ctrl    = memwbWb;
    assign o_byte       = exmemByte;
    assign o_illegal    = illegalQ;
    assign o_stall_cnt  = stallCnt;
    assign o_jump       = decJump && !i_stall && !i_flush && !loadUse;
    assign o_pc_write   = !i_stall && !luStall;
    assign o_ifid_write = !i_stall && !luStall;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed table-driven bench for ctrl_pipeline plus hand sequences for counter
// saturation (second instance with a 2-bit counter) and asynchronous reset mid-stall.
module tb_ctrl_pipeline;

    logic        clk;
    logic        rst;
    logic        i_valid;
    logic [5:0]  i_opcode;
    logic [4:0]  i_rs;
    logic [4:0]  i_rt;
    logic        i_flush;
    logic        i_stall;

    logic [3:0]  exCtrl, exCtrl2;
    logic [3:0]  memCtrl, memCtrl2;
    logic [1:0]  wbCtrl, wbCtrl2;
    logic        byteOut, byteOut2;
    logic        jumpOut, jumpOut2;
    logic        pcWrite, pcWrite2;
    logic        ifidWrite, ifidWrite2;
    logic        illegalOut, illegalOut2;
    logic [15:0] stallCnt;
    logic [1:0]  stallCnt2;

    int nChecks = 0;
    int nFail   = 0;

    ctrl_pipeline #(.OP_W(6), .REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_opcode(i_opcode),
        .i_rs(i_rs), .i_rt(i_rt), .i_flush(i_flush), .i_stall(i_stall),
        .o_ex_ctrl(exCtrl), .o_mem_ctrl(memCtrl), .o_wb_ctrl(wbCtrl),
        .o_byte(byteOut), .o_jump(jumpOut), .o_pc_write(pcWrite),
        .o_ifid_write(ifidWrite), .o_illegal(illegalOut), .o_stall_cnt(stallCnt)
    );

    ctrl_pipeline #(.OP_W(6), .REG_W(5), .CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_opcode(i_opcode),
        .i_rs(i_rs), .i_rt(i_rt), .i_flush(i_flush), .i_stall(i_stall),
        .o_ex_ctrl(exCtrl2), .o_mem_ctrl(memCtrl2), .o_wb_ctrl(wbCtrl2),
        .o_byte(byteOut2), .o_jump(jumpOut2), .o_pc_write(pcWrite2),
        .o_ifid_write(ifidWrite2), .o_illegal(illegalOut2), .o_stall_cnt(stallCnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        fl;
        logic        st;
        logic [3:0]  ex;
        logic [3:0]  mem;
        logic [1:0]  wb;
        logic        by;
        logic        pcw;
        logic        jmp;
        logic        ill;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic fl, input logic st,
                        input logic [3:0] ex, input logic [3:0] mem, input logic [1:0] wb,
                        input logic by, input logic pcw, input logic jmp, input logic ill,
                        input logic [15:0] cnt);
        vec_t t;
        t.v = v; t.op = op; t.rs = rs; t.rt = rt; t.fl = fl; t.st = st;
        t.ex = ex; t.mem = mem; t.wb = wb; t.by = by; t.pcw = pcw;
        t.jmp = jmp; t.ill = ill; t.cnt = cnt;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic fl, input logic st);
        i_valid = v; i_opcode = op; i_rs = rs; i_rt = rt; i_flush = fl; i_stall = st;
    endtask

    task automatic step(input logic v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic fl, input logic st);
        @(posedge clk);
        #1;
        drive(v, op, rs, rt, fl, st);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        //   v  op rs rt fl st |  ex       mem      wb    by pcw jmp ill cnt
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        addv(1,  0, 1, 2, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        addv(1,  8, 3, 4, 0, 0,  4'b1100, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        addv(0,  0, 0, 0, 0, 0,  4'b0111, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b10, 0, 1, 0, 0, 0);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b10, 0, 1, 0, 0, 0);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        // lw r5 followed by dependent add: one bubble
        addv(1, 35, 1, 5, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 0);
        addv(1,  0, 5, 6, 0, 0,  4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 0);
        addv(1,  0, 5, 6, 0, 0,  4'b0000, 4'b0010, 2'b00, 0, 1, 0, 0, 1);
        addv(0,  0, 0, 0, 0, 0,  4'b1100, 4'b0000, 2'b11, 0, 1, 0, 0, 1);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 1);
        addv(1, 35, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b10, 0, 1, 0, 0, 1);
        addv(1,  0, 0, 0, 0, 0,  4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 1);
        addv(1, 35, 1, 5, 0, 0,  4'b1100, 4'b0010, 2'b00, 0, 1, 0, 0, 1);
        addv(1, 43, 1, 5, 0, 0,  4'b0001, 4'b0000, 2'b11, 0, 0, 0, 0, 1);
        addv(1, 43, 1, 5, 0, 0,  4'b0000, 4'b0010, 2'b10, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0001, 4'b0000, 2'b11, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0001, 2'b00, 0, 1, 0, 0, 2);
        // flush with dependent add in ID: no bubble count, PC keeps moving
        addv(1, 35, 1, 5, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        addv(1,  0, 5, 6, 1, 0,  4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        addv(1,  0, 5, 6, 0, 0,  4'b0000, 4'b0010, 2'b00, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b1100, 4'b0000, 2'b11, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        // external stall for 3 clks with j in ID
        addv(1,  8, 1, 2, 0, 0,  4'b0000, 4'b0000, 2'b10, 0, 1, 0, 0, 2);
        addv(1,  5, 3, 4, 0, 0,  4'b0111, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        addv(1,  2, 0, 0, 0, 1,  4'b0010, 4'b0000, 2'b00, 0, 0, 0, 0, 2);
        addv(1,  2, 0, 0, 0, 1,  4'b0010, 4'b0000, 2'b00, 0, 0, 0, 0, 2);
        addv(1,  2, 0, 0, 0, 1,  4'b0010, 4'b0000, 2'b00, 0, 0, 0, 0, 2);
        addv(1,  2, 0, 0, 0, 0,  4'b0010, 4'b0000, 2'b00, 0, 1, 1, 0, 2);
        addv(0, 63, 0, 0, 0, 0,  4'b0000, 4'b0100, 2'b10, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        // unknown opcode: single-cycle illegal pulse
        addv(1, 63, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 1, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        // lb / sb byte flag through EX/MEM
        addv(1, 32, 1, 7, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        addv(1, 40, 2, 8, 0, 0,  4'b0001, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0001, 4'b0010, 2'b00, 1, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0001, 2'b11, 1, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        // beq then lui
        addv(1,  4, 1, 2, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        addv(1, 15, 0, 3, 0, 0,  4'b0010, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0111, 4'b1000, 2'b00, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b10, 0, 1, 0, 0, 2);
        addv(0,  0, 0, 0, 0, 0,  4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 2);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ex", 32'(exCtrl), 32'h0);
        chk("reset_cnt", 32'(stallCnt), 32'h0);
        chk("reset_pcw", 32'(pcWrite), 32'h1);
        rst = 1'b0;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].fl, vecs[i].st);
            chk($sformatf("v%0d_ex", i),   32'(exCtrl),     32'(vecs[i].ex));
            chk($sformatf("v%0d_mem", i),  32'(memCtrl),    32'(vecs[i].mem));
            chk($sformatf("v%0d_wb", i),   32'(wbCtrl),     32'(vecs[i].wb));
            chk($sformatf("v%0d_byte", i), 32'(byteOut),    32'(vecs[i].by));
            chk($sformatf("v%0d_pcw", i),  32'(pcWrite),    32'(vecs[i].pcw));
            chk($sformatf("v%0d_ifid", i), 32'(ifidWrite),  32'(vecs[i].pcw));
            chk($sformatf("v%0d_jump", i), 32'(jumpOut),    32'(vecs[i].jmp));
            chk($sformatf("v%0d_ill", i),  32'(illegalOut), 32'(vecs[i].ill));
            chk($sformatf("v%0d_cnt", i),  32'(stallCnt),   32'(vecs[i].cnt));
        end

        // three more load-use hazards: 5 total, 2-bit counter saturates at 3
        for (int k = 0; k < 3; k++) begin
            step(1, 35, 1, 9, 0, 0);
            step(1, 0, 9, 1, 0, 0);
            chk($sformatf("sat%0d_pcw", k), 32'(pcWrite), 32'h0);
            chk($sformatf("sat%0d_ex", k), 32'(exCtrl), 32'h1);
            step(1, 0, 9, 1, 0, 0);
            chk($sformatf("sat%0d_pcw_resume", k), 32'(pcWrite), 32'h1);
            step(0, 0, 0, 0, 0, 0);
            chk($sformatf("sat%0d_ex_add", k), 32'(exCtrl), 32'hC);
        end
        chk("cnt16_after5", 32'(stallCnt), 32'd5);
        chk("cnt2_saturated", 32'(stallCnt2), 32'd3);

        // asynchronous reset while externally stalled
        step(1, 35, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        chk("prerst_ex", 32'(exCtrl), 32'h1);
        chk("prerst_pcw", 32'(pcWrite), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("asyncrst_ex", 32'(exCtrl), 32'h0);
        chk("asyncrst_mem", 32'(memCtrl), 32'h0);
        chk("asyncrst_wb", 32'(wbCtrl), 32'h0);
        chk("asyncrst_cnt", 32'(stallCnt), 32'h0);
        chk("asyncrst_cnt2", 32'(stallCnt2), 32'h0);
        chk("asyncrst_pcw_stalled", 32'(pcWrite), 32'h0);
        i_stall = 1'b0;
        #1;
        chk("asyncrst_pcw", 32'(pcWrite), 32'h1);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
